diff_commit_queue: RTL and testbench

- Transmitter side of the dual-line WB-to-diff commit interface.
- Accepts up to two retired-instruction records per cycle from WB: line1 is older, line2 is younger.
- Buffers the records in program order and emits one record per cycle on a valid/ready stream to the trace/difftest consumer, tagged with a commit sequence number.
- Sits between the WB stage and the diff trace sink; asserts backpressure toward WB.

---
 rtl/diff_commit_queue.sv | 121 ++++++++++++
 tb/tb_diff_commit_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/diff_commit_queue.sv
// In-order commit queue between WB and the difftest sink: takes up to two records per cycle and emits one per cycle.
// Optional perf counters are enabled by defining DIFF_COMMIT_QUEUE_PERF_EN.
module diff_commit_queue #(
  parameter int REC_W = 102,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             line1_valid_i,
  input  logic [REC_W-1:0] line1_rec_i,
  input  logic             line2_valid_i,
  input  logic [REC_W-1:0] line2_rec_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [REC_W-1:0] out_rec_o,
  output logic [31:0]      out_seq_o,
  input  logic             out_ready_i,
  output logic [PTR_W:0]   count_o,
  output logic             overflow_o
`ifdef DIFF_COMMIT_QUEUE_PERF_EN
  ,
  output logic [31:0]      perf_commit_o,
  output logic [31:0]      perf_dual_o,
  output logic [31:0]      perf_stall_o
`endif
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_seq;
  logic             r_overflow;

  logic [PTR_W:0]   w_free;
  logic             w_any;
  logic             w_dual;
  logic             w_push_ok;
  logic             w_pop;
  logic [1:0]       w_npush;
  logic [PTR_W-1:0] w_tail1;

  // Ready depends only on registered occupancy so WB never sees a combinational path from the sink.
  assign w_free     = DEPTH_C - r_count;
  assign in_ready_o = (w_free >= (PTR_W+1)'(2));
  assign w_any      = line1_valid_i | line2_valid_i;
  assign w_dual     = line1_valid_i & line2_valid_i;
  assign w_push_ok  = in_ready_o & ~flush_i;
  assign w_pop      = (r_count != '0) & out_ready_i & ~flush_i;
  assign w_npush    = w_push_ok ? ({1'b0, line1_valid_i} + {1'b0, line2_valid_i}) : 2'd0;
  assign w_tail1    = r_tail + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      if (line1_valid_i) begin
        r_mem[r_tail] <= line1_rec_i;
        if (line2_valid_i) r_mem[w_tail1] <= line2_rec_i;
      end else if (line2_valid_i) begin
        r_mem[r_tail] <= line2_rec_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_any & ~in_ready_o) r_overflow <= 1'b1;
      // Flush keeps the sequence counter so trace numbering continues across pipeline clears.
      if (flush_i) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_pop) begin
          r_head <= r_head + PTR_W'(1);
          r_seq  <= r_seq + 32'd1;
        end
        r_tail  <= r_tail + PTR_W'(w_npush);
        r_count <= r_count + (PTR_W+1)'(w_npush) - (PTR_W+1)'(w_pop);
      end
    end
  end

  assign out_valid_o = (r_count != '0);
  assign out_rec_o   = r_mem[r_head];
  assign out_seq_o   = r_seq;
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;

`ifdef DIFF_COMMIT_QUEUE_PERF_EN
  logic [31:0] r_perf_commit;
  logic [31:0] r_perf_dual;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_commit <= '0;
      r_perf_dual   <= '0;
      r_perf_stall  <= '0;
    end else begin
      r_perf_commit <= r_perf_commit + 32'(w_npush);
      if (w_push_ok & w_dual) r_perf_dual <= r_perf_dual + 32'd1;
      if (~in_ready_o & w_any) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_commit_o = r_perf_commit;
  assign perf_dual_o   = r_perf_dual;
  assign perf_stall_o  = r_perf_stall;
`endif

endmodule

// File: tb/tb_diff_commit_queue.sv
// Directed bench for diff_commit_queue: a queue-level reference model checked every cycle plus literal spot checks.
module tb_diff_commit_queue;

  localparam int REC_W = 102;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk;
  logic             rst_n;
  logic             flush_i;
  logic             line1_valid_i;
  logic [REC_W-1:0] line1_rec_i;
  logic             line2_valid_i;
  logic [REC_W-1:0] line2_rec_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [REC_W-1:0] out_rec_o;
  logic [31:0]      out_seq_o;
  logic             out_ready_i;
  logic [PTR_W:0]   count_o;
  logic             overflow_o;
`ifdef DIFF_COMMIT_QUEUE_PERF_EN
  logic [31:0]      perf_commit_o;
  logic [31:0]      perf_dual_o;
  logic [31:0]      perf_stall_o;
`endif

  diff_commit_queue #(.REC_W(REC_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush_i),
    .line1_valid_i(line1_valid_i),
    .line1_rec_i(line1_rec_i),
    .line2_valid_i(line2_valid_i),
    .line2_rec_i(line2_rec_i),
    .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o),
    .out_rec_o(out_rec_o),
    .out_seq_o(out_seq_o),
    .out_ready_i(out_ready_i),
    .count_o(count_o),
    .overflow_o(overflow_o)
`ifdef DIFF_COMMIT_QUEUE_PERF_EN
    ,
    .perf_commit_o(perf_commit_o),
    .perf_dual_o(perf_dual_o),
    .perf_stall_o(perf_stall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errCount = 0;
  int chkCount = 0;
  bit chkEn = 1'b0;

  // Reference model: a plain program-order list of records plus a sequence number.
  logic [REC_W-1:0] mq [$];
  logic [31:0]      mSeq = 32'd0;
  bit               mOvf = 1'b0;

  function automatic logic [REC_W-1:0] mkRec(input logic [31:0] pc);
    logic [31:0] inst;
    inst = pc ^ 32'hA5A5_5A5A;
    return {pc, inst, 1'b1, pc[6:2], ~pc};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    chkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mSeq = 32'd0;
    mOvf = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs that were presented for that edge.
  task automatic modelStep();
    bit ready;
    bit pop;
    ready = (DEPTH - mq.size()) >= 2;
    pop   = (mq.size() != 0) && out_ready_i;
    if ((line1_valid_i || line2_valid_i) && !ready) mOvf = 1'b1;
    if (flush_i) begin
      mq.delete();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        mSeq = mSeq + 32'd1;
      end
      if (ready) begin
        if (line1_valid_i) mq.push_back(line1_rec_i);
        if (line2_valid_i) mq.push_back(line2_rec_i);
      end
    end
  endtask

  task automatic applyStimulus(input bit v1, input logic [31:0] pc1, input bit v2,
                               input logic [31:0] pc2, input bit ordy, input bit fl);
    line1_valid_i = v1;
    line1_rec_i   = mkRec(pc1);
    line2_valid_i = v2;
    line2_rec_i   = mkRec(pc2);
    out_ready_i   = ordy;
    flush_i       = fl;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, ordy, 1'b0);
  endtask

  // Every cycle: occupancy, ready, overflow and (when valid) head record and sequence must match the model.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("count", 128'(count_o), 128'(mq.size()));
      checkOutput("in_ready", 128'(in_ready_o), 128'((DEPTH - mq.size()) >= 2));
      checkOutput("out_valid", 128'(out_valid_o), 128'(mq.size() != 0));
      checkOutput("overflow", 128'(overflow_o), 128'(mOvf));
      if (mq.size() != 0) begin
        checkOutput("out_rec", 128'(out_rec_o), 128'(mq[0]));
        checkOutput("out_seq", 128'(out_seq_o), 128'(mSeq));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0;
    line1_valid_i = 1'b0;
    line1_rec_i = '0;
    line2_valid_i = 1'b0;
    line2_rec_i = '0;
    out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    chkEn = 1'b1;

    checkOutput("rst_count", 128'(count_o), 128'(0));
    checkOutput("rst_valid", 128'(out_valid_o), 128'(0));
    checkOutput("rst_ovf", 128'(overflow_o), 128'(0));
    checkOutput("rst_seq", 128'(out_seq_o), 128'(0));
    checkOutput("rst_ready", 128'(in_ready_o), 128'(1));

    // Dual push then drain with the sink always ready.
    applyStimulus(1'b1, 32'h1c00_0000, 1'b1, 32'h1c00_0004, 1'b1, 1'b0);
    checkOutput("t1_pc0", 128'(out_rec_o[101:70]), 128'(32'h1c00_0000));
    checkOutput("t1_seq0", 128'(out_seq_o), 128'(0));
    idle(1'b1, 1);
    checkOutput("t1_pc1", 128'(out_rec_o[101:70]), 128'(32'h1c00_0004));
    checkOutput("t1_seq1", 128'(out_seq_o), 128'(1));
    idle(1'b1, 1);
    checkOutput("t1_cnt0", 128'(count_o), 128'(0));

    // Only line2 valid.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h1c00_0010, 1'b0, 1'b0);
    checkOutput("t2_pc", 128'(out_rec_o[101:70]), 128'(32'h1c00_0010));
    checkOutput("t2_cnt", 128'(count_o), 128'(1));
    idle(1'b1, 1);

    // Fill to full, then offer once more.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h1c00_0100 + 32'(8*i), 1'b1, 32'h1c00_0104 + 32'(8*i), 1'b0, 1'b0);
    checkOutput("t3_full", 128'(count_o), 128'(8));
    checkOutput("t3_ready0", 128'(in_ready_o), 128'(0));
    applyStimulus(1'b1, 32'h1c00_0200, 1'b1, 32'h1c00_0204, 1'b0, 1'b0);
    checkOutput("t3_cnt8", 128'(count_o), 128'(8));
    checkOutput("t3_ovf", 128'(overflow_o), 128'(1));
    checkOutput("t3_head", 128'(out_rec_o[101:70]), 128'(32'h1c00_0100));
    idle(1'b1, 8);

    // Occupancy 6, dual push with a same-cycle pop.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h1c00_0300 + 32'(8*i), 1'b1, 32'h1c00_0304 + 32'(8*i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1c00_0400, 1'b1, 32'h1c00_0404, 1'b1, 1'b0);
    checkOutput("t4_cnt7", 128'(count_o), 128'(7));
    checkOutput("t4_ready0", 128'(in_ready_o), 128'(0));
    checkOutput("t4_head", 128'(out_rec_o[101:70]), 128'(32'h1c00_0304));
    idle(1'b1, 7);

    // Sequence wrap: preset the counter to all ones.
    force dut.r_seq = 32'hFFFF_FFFF;
    #1;
    release dut.r_seq;
    mSeq = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 32'h1c00_0500, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t5_seqmax", 128'(out_seq_o), 128'(32'hFFFF_FFFF));
    applyStimulus(1'b1, 32'h1c00_0504, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t5_seqwrap", 128'(out_seq_o), 128'(0));
    checkOutput("t5_pc", 128'(out_rec_o[101:70]), 128'(32'h1c00_0504));
    idle(1'b1, 1);

    // Flush at occupancy 5 overrides a dual push and pop.
    applyStimulus(1'b1, 32'h1c00_0600, 1'b1, 32'h1c00_0604, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1c00_0608, 1'b1, 32'h1c00_060c, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1c00_0610, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_cnt5", 128'(count_o), 128'(5));
    applyStimulus(1'b1, 32'h1c00_0700, 1'b1, 32'h1c00_0704, 1'b1, 1'b1);
    checkOutput("t6_flcnt", 128'(count_o), 128'(0));
    checkOutput("t6_flvalid", 128'(out_valid_o), 128'(0));
    checkOutput("t6_flseq", 128'(out_seq_o), 128'(1));
    checkOutput("t6_flovf", 128'(overflow_o), 128'(1));

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, 32'h1c00_0800, 1'b1, 32'h1c00_0804, 1'b0, 1'b0);
    line1_valid_i = 1'b0;
    line2_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_arvalid", 128'(out_valid_o), 128'(0));
    checkOutput("t6_arcnt", 128'(count_o), 128'(0));
    checkOutput("t6_arovf", 128'(overflow_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h1c00_0900, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t6_postseq", 128'(out_seq_o), 128'(0));
    idle(1'b1, 2);

    chkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

endmodule
